receiver_ctrl: RTL and testbench
================================

// Module: receiver_ctrl
// PURPOSE
//   UART receive front end and control, one stage upstream of the receiver SIPO.
//   Synchronises the raw rx pin, finds the start bit, and samples each data bit mid-bit.
//   Drives shift_en/data_o into the SIPO: exactly 8 single-cycle pulses per frame, LSB first.
//   Checks the stop bit and flags frame completion or framing error.
// PARAMETERS
//   CLKS_PER_BIT  16  clk cycles per UART bit; even, >= 4 (16 is the sim value)
//   DATA_BITS     8   data bits per frame; must match the SIPO width
// PORTS
//   clk        in   1  system clock, rising edge
//   rst        in   1  synchronous, active-high reset
//   rx_i       in   1  raw serial line; idles high; async to clk
//   shift_en   out  1  one-cycle pulse per sampled data bit; feeds SIPO shift_en
//   data_o     out  1  sampled bit; valid in any cycle where shift_en=1; feeds SIPO data_i
//   rx_done    out  1  one-cycle pulse: stop bit sampled high, SIPO byte complete
//   frame_err  out  1  one-cycle pulse: stop bit sampled low
//   busy       out  1  high in every state except IDLE
// BEHAVIOUR
//   Reset: synchronous, active-high, wins over all other activity.
//     - State -> IDLE; counters -> 0; sync flops -> 1.
//     - All outputs -> 0 (data_o -> 0).
//     - Reset mid-frame abandons the frame: no further shift_en, rx_done or frame_err.
//   rx_i passes through a 2-flop synchroniser to give rx_s (2-cycle latency).
//   Counters: cnt is log2(CLKS_PER_BIT) bits wide; bit_idx is log2(DATA_BITS)+1 bits wide.
//   States:
//     IDLE: on rx_s==0 -> START with cnt=0.
//     START: at cnt==CLKS_PER_BIT/2-1 (mid start bit):
//       - rx_s==0 -> DATA with cnt=0, bit_idx=0.
//       - rx_s==1 -> IDLE (glitch reject). No output is asserted.
//     DATA: at cnt==CLKS_PER_BIT-1:
//       - Register data_o=rx_s and pulse shift_en in the same cycle; bit_idx++; cnt=0.
//       - After pulse DATA_BITS-1 -> STOP.
//     STOP: at cnt==CLKS_PER_BIT-1, sample rx_s:
//       - 1 -> pulse rx_done, go to IDLE.
//       - 0 -> pulse frame_err, go to RECOVER.
//     RECOVER: wait for rx_s==1, then go to IDLE. This blocks a false start during a break.
//   Timing:
//     - All samples fall mid-bit. Consecutive shift_en pulses are exactly CLKS_PER_BIT apart.
//     - rx_done occurs CLKS_PER_BIT after the last shift_en.
//   Pulses:
//     - shift_en, rx_done and frame_err are never high for 2 consecutive cycles.
//     - rx_done and frame_err are mutually exclusive.
//   Back-to-back frames: a start edge in the cycle after rx_done is accepted; no idle gap required.
//   data_o holds its last value between pulses.
// STRUCTURE
//   uart_pkg:
//     - rx_state_t enum {IDLE, START, DATA, STOP, RECOVER}
//     - UART_DATA_BITS=8, UART_CLKS_PER_BIT=16 (shared with transmitter and SIPO)
//   Sub-module rx_sync: 2-flop synchroniser, resets to 1. Everything else is a single FSM
//   plus two counters.
// TESTING (CLKS_PER_BIT=16, 20 ns clk period)
//   1. Frame 0xA5: start, 1,0,1,0,0,1,0,1, stop=1 ->
//      - 8 shift_en pulses 16 cycles apart; data_o 1,0,1,0,0,1,0,1
//      - one rx_done; frame_err never asserted
//   2. Glitch: rx_i low for 4 cycles, then high -> no shift_en; busy falls back to 0;
//      a following 0x3C frame is received correctly.
//   3. Framing error: 0x5A with stop=0, line held low 40 cycles ->
//      - 8 shift_en pulses, then one frame_err, no rx_done
//      - busy stays 1 until rx_i returns high
//   4. Back-to-back: 0x00 then 0xFF with no idle gap -> 16 shift_en pulses and 2 rx_done;
//      second frame data_o all 1.
//   5. Reset mid-frame: assert rst after the 3rd shift_en ->
//      - next edge: all outputs 0, busy=0
//      - no pulses until a new start bit; a following 0x81 frame is received correctly
//   6. Idle line: rx_i=1 for 200 cycles after reset -> busy and all pulse outputs stay 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry used by the transmitter, the receiver and the SIPO,
// plus the receive-side state encoding.
package uart_pkg;

    localparam int UART_DATA_BITS    = 8;
    localparam int UART_CLKS_PER_BIT = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        RECOVER = 3'd4
    } rx_state_t;

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchroniser for the asynchronous rx pin; flops reset to the idle-high line level.
module rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic sync_p0;
    logic sync_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
        end else begin
            sync_p0 <= d;
            sync_p1 <= sync_p0;
        end
    end

    assign q = sync_p1;

endmodule

// File: rtl/receiver_ctrl.sv
// UART receive front end: finds the start bit, samples each data bit mid-bit and feeds the
// SIPO one shift_en pulse per bit, then reports stop-bit success or framing error.
module receiver_ctrl
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int DATA_BITS    = UART_DATA_BITS
) (
    input  logic clk,
    input  logic rst,
    input  logic rx_i,
    output logic shift_en,
    output logic data_o,
    output logic rx_done,
    output logic frame_err,
    output logic busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS) + 1;
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    rx_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] bit_idx;
    logic             rx_s;

    rx_sync u_rx_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx_i),
        .q   (rx_s)
    );

    // Half a bit in START re-centres the counter so every later sample lands mid-bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift_en  <= 1'b0;
            data_o    <= 1'b0;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            shift_en  <= 1'b0;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end
                START: begin
                    if (cnt == CNT_HALF) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt      <= '0;
                        data_o   <= rx_s;
                        shift_en <= 1'b1;
                        bit_idx  <= bit_idx + 1'b1;
                        if (bit_idx == IDX_LAST) begin
                            state <= STOP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (rx_s) begin
                            rx_done <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= RECOVER;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                // Holding here until the line is high again stops a break being read as a start bit.
                RECOVER: begin
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_receiver_ctrl.sv
// Scoreboard bench for receiver_ctrl: stimulus queues the expected bit/stop events of each
// frame, a negedge monitor pops and compares them as the DUT pulses.
module tb_receiver_ctrl;

    localparam int CPB = 16;
    localparam int NB  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx_i = 1'b1;
    logic shift_en, data_o, rx_done, frame_err, busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int frame_start = 0;
    int exp_q[$];

    receiver_ctrl #(.CLKS_PER_BIT(CPB), .DATA_BITS(NB)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_i      (rx_i),
        .shift_en  (shift_en),
        .data_o    (data_o),
        .rx_done   (rx_done),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Event codes: 0/1 = shift of that bit value, 2 = rx_done, 3 = frame_err.
    // Leaves the line low after a bad stop bit; the caller decides when it returns high.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        for (int i = 0; i < NB; i++) exp_q.push_back(int'(b[i]));
        exp_q.push_back(stop ? 2 : 3);
        rx_i = 1'b0;
        frame_start = cyc;
        tick(CPB);
        for (int i = 0; i < NB; i++) begin
            rx_i = b[i];
            tick(CPB);
        end
        rx_i = stop;
        tick(CPB);
        if (stop) rx_i = 1'b1;
    endtask

    task automatic check_quiet(input string name);
        check({name, "_shift_en"}, int'(shift_en), 0);
        check({name, "_data_o"}, int'(data_o), 0);
        check({name, "_rx_done"}, int'(rx_done), 0);
        check({name, "_frame_err"}, int'(frame_err), 0);
        check({name, "_busy"}, int'(busy), 0);
    endtask

    // Monitor: event order/value, mid-bit placement of the first sample, bit spacing, hold of data_o.
    int   idx = 0;
    int   last_cyc = 0;
    logic last_data = 1'b0;
    int   npulse;
    int   code;
    always @(negedge clk) begin
        if (rst) begin
            idx = 0;
            last_data = 1'b0;
        end else begin
            npulse = int'(shift_en) + int'(rx_done) + int'(frame_err);
            if (npulse > 1) check("pulse_exclusive", npulse, 1);
            if (!shift_en) check("data_hold", int'(data_o), int'(last_data));
            if (npulse >= 1) begin
                code = shift_en ? int'(data_o) : (rx_done ? 2 : 3);
                if (exp_q.size() == 0) check("unexpected_pulse", code, -1);
                else check("event", code, exp_q.pop_front());
                if (idx == 0) begin
                    if (shift_en)
                        check("first_sample_midbit",
                              int'((cyc - frame_start) >= CPB + CPB/4 &&
                                   (cyc - frame_start) <= CPB + 3*CPB/4 + 3), 1);
                end else begin
                    check("pulse_spacing", cyc - last_cyc, CPB);
                end
                last_cyc = cyc;
                if (shift_en) begin
                    last_data = data_o;
                    idx++;
                end else begin
                    idx = 0;
                end
            end
        end
    end

    initial begin
        logic [7:0] b;
        logic       stop;
        int         gap;

        rst = 1'b1;
        tick(3);
        check_quiet("reset");
        rst = 1'b0;

        // Idle line: nothing should happen.
        for (int i = 0; i < 200; i++) begin
            tick(1);
            check("idle_busy", int'(busy), 0);
        end

        send_frame(8'hA5, 1'b1);
        tick(20);

        // Glitch shorter than half a bit must be rejected.
        rx_i = 1'b0;
        tick(4);
        rx_i = 1'b1;
        tick(20);
        check("glitch_busy", int'(busy), 0);
        send_frame(8'h3C, 1'b1);
        tick(20);

        // Framing error with the line held low 40 cycles from the stop bit.
        send_frame(8'h5A, 1'b0);
        tick(24);
        check("break_busy", int'(busy), 1);
        rx_i = 1'b1;
        tick(6);
        check("recover_busy", int'(busy), 0);
        tick(10);

        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        tick(20);

        // Reset during bit 3, after the third shift_en.
        b = 8'h6B;
        for (int i = 0; i < 3; i++) exp_q.push_back(int'(b[i]));
        rx_i = 1'b0;
        frame_start = cyc;
        tick(CPB);
        for (int i = 0; i < 3; i++) begin
            rx_i = b[i];
            tick(CPB);
        end
        rx_i = b[3];
        tick(4);
        check("pre_reset_pending", exp_q.size(), 0);
        rst = 1'b1;
        tick(1);
        check_quiet("midframe_reset");
        rst = 1'b0;
        rx_i = 1'b1;
        tick(40);
        check("post_reset_busy", int'(busy), 0);
        send_frame(8'h81, 1'b1);
        tick(20);

        // Randomised frames, stop bits and gaps (gap 0 = back-to-back).
        for (int f = 0; f < 20; f++) begin
            b = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            send_frame(b, stop);
            if (!stop) begin
                tick($urandom_range(4, 20));
                rx_i = 1'b1;
                gap = $urandom_range(4, 20);
            end else begin
                gap = $urandom_range(0, 10);
            end
            tick(gap);
        end

        begin
            int budget = 100;
            while (exp_q.size() != 0 && budget > 0) begin
                tick(1);
                budget--;
            end
        end
        check("drain_pending", exp_q.size(), 0);
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
